axis_matvec_fx: RTL and testbench
=================================

Name: axis_matvec_fx

Overview:
Parametrised AXI4-Stream vector-matrix multiply engine; the successor to the fixed 4x4 dot block. Weights are loadable at runtime over a dedicated weight stream rather than built in. Arithmetic is signed fixed-point with configurable width, rounding and saturation. It sits between the DMA MM2S/S2MM streams as a hardware accelerator: an input vector of ROWS words is consumed and COLS result words are produced, where out[c] = sum_r x[r]*w[r][c].

Parameters:
ROWS, 4, input vector length (>=1)
COLS, 4, output vector length (>=1)
DATA_W, 32, stream word width; signed two's complement
FRAC_W, 16, fractional bits of data and weights (Q(DATA_W-FRAC_W).FRAC_W)
ACC_W, 2*DATA_W+$clog2(ROWS), accumulator width; never overflows internally

Ports:
aclk  in  1  clock; all logic rising-edge
aresetn  in  1  asynchronous active-low reset
WEIGHT_AXIS_TDATA  in  DATA_W  weight word, row-major order (index r*COLS+c)
WEIGHT_AXIS_TLAST  in  1  marks final weight word
WEIGHT_AXIS_TVALID  in  1  weight valid
WEIGHT_AXIS_TREADY  out  1  weight ready
INPUT_AXIS_TDATA  in  DATA_W  input vector element x[r]
INPUT_AXIS_TLAST  in  1  marks element ROWS-1
INPUT_AXIS_TVALID  in  1  input valid
INPUT_AXIS_TREADY  out  1  input ready
OUTPUT_AXIS_TDATA  out  DATA_W  result element out[c]
OUTPUT_AXIS_TLAST  out  1  high with element COLS-1
OUTPUT_AXIS_TVALID  out  1  output valid
OUTPUT_AXIS_TREADY  in  1  output ready
weights_valid  out  1  a complete weight set is loaded
frame_error  out  1  sticky: TLAST mismatch seen on either input stream

Behaviour:
- Reset (aresetn low, asynchronous): state IDLE; all counters 0; all TREADY/TVALID/TLAST 0; OUTPUT_AXIS_TDATA 0; weights_valid 0; frame_error 0. Weight RAM contents are don't-care but invalid. Reset mid-frame aborts everything with no partial output.
- Handshake: a transfer occurs on a rising edge with TVALID&&TREADY. While OUTPUT_AXIS_TVALID is high, TDATA/TLAST are held stable until accepted.
- FSM states: IDLE, LOAD_W, RECV, MAC, SEND.
- IDLE: WEIGHT_AXIS_TREADY=1. INPUT_AXIS_TREADY=weights_valid.
  - Weight beat accepted -> LOAD_W.
  - Otherwise input beat accepted -> RECV.
  - If both are offered in the same cycle, the weight stream wins and the input is not accepted.
- LOAD_W: WEIGHT_AXIS_TREADY=1. Stores ROWS*COLS words; weights_valid drops to 0 on the first beat.
  - On the ROWS*COLS-th beat -> IDLE with weights_valid=1.
  - TLAST early (before that beat): set frame_error, drop the beat's data, weights_valid stays 0, -> IDLE.
  - TLAST missing on the final beat: set frame_error, but weights_valid=1.
- RECV: INPUT_AXIS_TREADY=1. Stores x[0..ROWS-1] (the first beat was taken in IDLE). The ROWS-th beat -> MAC with c=0.
  - TLAST mismatch (early or missing) sets frame_error.
  - An early-TLAST frame is padded with zeros and processed normally.
- MAC: one product x[r]*w[r][c] accumulated per cycle for ROWS cycles (full-precision signed), then -> SEND.
  - Latency from the last input handshake to OUTPUT_AXIS_TVALID is ROWS+1 cycles.
  - Between outputs, the gap after each handshake is ROWS+1 cycles.
- Result formatting: acc + 2^(FRAC_W-1), then arithmetic shift right by FRAC_W (round half toward +inf). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- SEND: OUTPUT_AXIS_TVALID=1 and OUTPUT_AXIS_TLAST=(c==COLS-1).
  - On handshake: if c<COLS-1, c++, clear the accumulator, -> MAC.
  - Else -> IDLE (weights retained, weights_valid unchanged).
- Weights are never modified outside LOAD_W. INPUT and WEIGHT TREADY are 0 in MAC and SEND.
- frame_error clears only on reset.

Test Plan:
- Load w[r][c]=r+c+1 (0x00010000...), TLAST on word 16; send x=[1,2,3,4] (0x00010000,0x00020000,0x00030000,0x00040000) with TLAST on word 4 -> outputs 0x001E0000, 0x00280000, 0x00320000, 0x003C0000; TLAST only on the 4th; first TVALID exactly 5 cycles after the last input handshake; frame_error=0.
- Same vector with OUTPUT_AXIS_TREADY held low 10 cycles on each word -> identical data; TDATA stable while stalled; no words lost or duplicated.
- Input offered after reset with no weights loaded -> INPUT_AXIS_TREADY stays 0 for 100 cycles; no output.
- Saturation and sign: all x=0x7FFF0000, all w=0x00020000 -> every output 0x7FFFFFFF. x=[0xFFFF8000,0,0,0], w[0][c]=0x00018000 -> every output 0xFFFF4000.
- Rounding: x=[0x00000001,0,0,0], w[0][0]=0x00008000 -> out[0]=0x00000001; with w[0][0]=0xFFFF8000 -> out[0]=0x00000000.
- Weight TLAST on word 10 -> frame_error=1, weights_valid=0, input blocked. Assert aresetn mid-SEND -> all outputs 0 immediately (asynchronously), flags cleared. Reload weights and rerun the first scenario -> passes.

Source files
------------

// File: rtl/axis_matvec_fx.sv
`timescale 1ns/1ps
// axis_matvec_fx
//   AXI4-Stream vector-matrix multiply engine. A weight set of ROWS*COLS words
//   is loaded over the weight stream (row-major, index r*COLS+c). Each input
//   frame of ROWS words x[r] then yields COLS result words
//   out[c] = sum_r x[r]*w[r][c]. The arithmetic is signed fixed point with
//   FRAC_W fractional bits, rounding half toward +inf and saturating to DATA_W.
//
// Ports
//   aclk, aresetn              clock (rising edge), async active-low reset
//   WEIGHT_AXIS_*              weight stream sink (TDATA, TLAST, TVALID, TREADY)
//   INPUT_AXIS_*               input vector sink  (TDATA, TLAST, TVALID, TREADY)
//   OUTPUT_AXIS_*              result source      (TDATA, TLAST, TVALID, TREADY)
//   weights_valid              a complete weight set is loaded
//   frame_error                sticky TLAST mismatch on either sink stream
module axis_matvec_fx #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 2 * DATA_W + $clog2(ROWS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] WEIGHT_AXIS_TDATA,
  input  logic              WEIGHT_AXIS_TLAST,
  input  logic              WEIGHT_AXIS_TVALID,
  output logic              WEIGHT_AXIS_TREADY,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  output logic              weights_valid,
  output logic              frame_error
);

  localparam int NW   = ROWS * COLS;
  localparam int W_CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int R_CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int C_CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int M_CW = $clog2(ROWS + 1);

  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (FRAC_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, RECV, MAC, SEND} state_t;

  state_t state, state_d;

  logic [W_CW-1:0]          w_cnt;
  logic [R_CW-1:0]          r_cnt;
  logic [M_CW-1:0]          x_len;
  logic [M_CW-1:0]          mac_r;
  logic [C_CW-1:0]          c_idx;
  logic signed [ACC_W-1:0]  acc;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     wv;
  logic                     wv_d;
  logic                     ferr;
  logic                     w_rdy;
  logic                     in_rdy;

  logic signed [DATA_W-1:0] w_mem [NW];
  logic signed [DATA_W-1:0] x_mem [ROWS];

  logic                     w_fire, in_fire, out_fire;
  logic                     w_final, in_final, mac_done, c_final;
  logic                     w_end, in_end;

  logic [R_CW-1:0]          r_sel;
  logic [W_CW-1:0]          w_idx;
  logic signed [DATA_W-1:0] x_sel, w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    acc_wide, rnd, shifted;
  logic [ACC_W-DATA_W+1:0]  hi;
  logic [DATA_W-1:0]        sat;

  // Weight beats take priority in IDLE: the input ready is withdrawn whenever
  // a weight beat is offered so the input word is never silently consumed.
  assign WEIGHT_AXIS_TREADY = w_rdy;
  assign INPUT_AXIS_TREADY  = in_rdy && !((state == IDLE) && WEIGHT_AXIS_TVALID);
  assign OUTPUT_AXIS_TDATA  = out_data;
  assign OUTPUT_AXIS_TLAST  = out_last;
  assign OUTPUT_AXIS_TVALID = out_valid;
  assign weights_valid      = wv;
  assign frame_error        = ferr;

  assign w_fire   = WEIGHT_AXIS_TVALID && w_rdy;
  assign in_fire  = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
  assign out_fire = out_valid && OUTPUT_AXIS_TREADY;

  assign w_final  = (w_cnt == W_CW'(NW - 1));
  assign in_final = (r_cnt == R_CW'(ROWS - 1));
  assign mac_done = (mac_r == M_CW'(ROWS));
  assign c_final  = (c_idx == C_CW'(COLS - 1));

  assign w_end    = w_fire && (w_final || WEIGHT_AXIS_TLAST);
  assign in_end   = in_fire && (in_final || INPUT_AXIS_TLAST);

  // Next state and next weights_valid.
  always_comb begin
    state_d = state;
    wv_d    = wv;
    if (w_fire) wv_d = w_final;
    case (state)
      IDLE: begin
        if (w_fire)       state_d = w_end ? IDLE : LOAD_W;
        else if (in_fire) state_d = in_end ? MAC : RECV;
      end
      LOAD_W: if (w_end)    state_d = IDLE;
      RECV:   if (in_end)   state_d = MAC;
      MAC:    if (mac_done) state_d = SEND;
      SEND:   if (out_fire) state_d = c_final ? IDLE : MAC;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_d;
  end

  // MAC operand selection. Elements beyond a short (early-TLAST) frame read
  // as zero through x_len instead of physically clearing the vector store.
  always_comb begin
    r_sel    = mac_done ? '0 : R_CW'(mac_r);
    w_idx    = W_CW'(int'(r_sel) * COLS + int'(c_idx));
    x_sel    = (mac_r < x_len) ? x_mem[r_sel] : '0;
    w_sel    = w_mem[w_idx];
    prod     = (2 * DATA_W)'(x_sel) * (2 * DATA_W)'(w_sel);
    prod_ext = ACC_W'(prod);
  end

  // Round half toward +inf, drop FRAC_W bits, then clamp to DATA_W. One extra
  // bit keeps the rounding add from wrapping at the accumulator extremes.
  always_comb begin
    acc_wide = (ACC_W + 1)'(acc);
    rnd      = acc_wide + HALF;
    shifted  = rnd >>> FRAC_W;
    hi       = shifted[ACC_W:DATA_W-1];
    if ((&hi) || !(|hi))   sat = shifted[DATA_W-1:0];
    else if (shifted[ACC_W]) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                     sat = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_cnt     <= '0;
      r_cnt     <= '0;
      x_len     <= '0;
      mac_r     <= '0;
      c_idx     <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      wv        <= 1'b0;
      ferr      <= 1'b0;
      w_rdy     <= 1'b0;
      in_rdy    <= 1'b0;
    end else begin
      wv     <= wv_d;
      w_rdy  <= (state_d == IDLE) || (state_d == LOAD_W);
      in_rdy <= (state_d == RECV) || ((state_d == IDLE) && wv_d);

      if (w_fire) begin
        w_cnt <= w_end ? '0 : w_cnt + 1'b1;
        if (w_final != WEIGHT_AXIS_TLAST) ferr <= 1'b1;
      end

      if (in_fire) begin
        r_cnt <= in_end ? '0 : r_cnt + 1'b1;
        if (in_final != INPUT_AXIS_TLAST) ferr <= 1'b1;
        if (in_end) begin
          x_len <= M_CW'(r_cnt) + 1'b1;
          acc   <= '0;
          mac_r <= '0;
          c_idx <= '0;
        end
      end

      // ROWS accumulate cycles, then one cycle to register the formatted word.
      if (state == MAC) begin
        if (!mac_done) begin
          acc   <= acc + prod_ext;
          mac_r <= mac_r + 1'b1;
        end else begin
          out_data  <= sat;
          out_valid <= 1'b1;
          out_last  <= c_final;
        end
      end

      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (c_final) begin
          c_idx <= '0;
        end else begin
          c_idx <= c_idx + 1'b1;
          acc   <= '0;
          mac_r <= '0;
        end
      end
    end
  end

  // Storage arrays carry no reset; their contents are qualified by
  // weights_valid and x_len.
  always_ff @(posedge aclk) begin
    if (w_fire && !(WEIGHT_AXIS_TLAST && !w_final))
      w_mem[w_cnt] <= WEIGHT_AXIS_TDATA;
    if (in_fire)
      x_mem[r_cnt] <= INPUT_AXIS_TDATA;
  end

endmodule

// File: tb/tb_axis_matvec_fx.sv
`timescale 1ns/1ps
// tb_axis_matvec_fx
//   Directed bench for axis_matvec_fx (4x4, Q16.16): weight load, vector
//   processing with and without output back-pressure, rounding, saturation,
//   frame errors and asynchronous reset.
module tb_axis_matvec_fx;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] WEIGHT_AXIS_TDATA;
  logic        WEIGHT_AXIS_TLAST;
  logic        WEIGHT_AXIS_TVALID;
  logic        WEIGHT_AXIS_TREADY;
  logic [31:0] INPUT_AXIS_TDATA;
  logic        INPUT_AXIS_TLAST;
  logic        INPUT_AXIS_TVALID;
  logic        INPUT_AXIS_TREADY;
  logic [31:0] OUTPUT_AXIS_TDATA;
  logic        OUTPUT_AXIS_TLAST;
  logic        OUTPUT_AXIS_TVALID;
  logic        OUTPUT_AXIS_TREADY;
  logic        weights_valid;
  logic        frame_error;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] wbuf    [16];
  logic [31:0] exp_out [4];

  always #5 aclk = ~aclk;

  axis_matvec_fx #(
    .ROWS   (4),
    .COLS   (4),
    .DATA_W (32),
    .FRAC_W (16)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .WEIGHT_AXIS_TDATA  (WEIGHT_AXIS_TDATA),
    .WEIGHT_AXIS_TLAST  (WEIGHT_AXIS_TLAST),
    .WEIGHT_AXIS_TVALID (WEIGHT_AXIS_TVALID),
    .WEIGHT_AXIS_TREADY (WEIGHT_AXIS_TREADY),
    .INPUT_AXIS_TDATA   (INPUT_AXIS_TDATA),
    .INPUT_AXIS_TLAST   (INPUT_AXIS_TLAST),
    .INPUT_AXIS_TVALID  (INPUT_AXIS_TVALID),
    .INPUT_AXIS_TREADY  (INPUT_AXIS_TREADY),
    .OUTPUT_AXIS_TDATA  (OUTPUT_AXIS_TDATA),
    .OUTPUT_AXIS_TLAST  (OUTPUT_AXIS_TLAST),
    .OUTPUT_AXIS_TVALID (OUTPUT_AXIS_TVALID),
    .OUTPUT_AXIS_TREADY (OUTPUT_AXIS_TREADY),
    .weights_valid      (weights_valid),
    .frame_error        (frame_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] d, input logic last);
    int n = 0;
    WEIGHT_AXIS_TDATA  = d;
    WEIGHT_AXIS_TLAST  = last;
    WEIGHT_AXIS_TVALID = 1'b1;
    @(negedge aclk);
    while (WEIGHT_AXIS_TREADY !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("w_tready_wait", 32'(WEIGHT_AXIS_TREADY), 32'd1);
    @(posedge aclk);
    #1;
    WEIGHT_AXIS_TVALID = 1'b0;
    WEIGHT_AXIS_TLAST  = 1'b0;
  endtask

  task automatic push_x(input logic [31:0] d, input logic last);
    int n = 0;
    INPUT_AXIS_TDATA  = d;
    INPUT_AXIS_TLAST  = last;
    INPUT_AXIS_TVALID = 1'b1;
    @(negedge aclk);
    while (INPUT_AXIS_TREADY !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("in_tready_wait", 32'(INPUT_AXIS_TREADY), 32'd1);
    @(posedge aclk);
    #1;
    INPUT_AXIS_TVALID = 1'b0;
    INPUT_AXIS_TLAST  = 1'b0;
  endtask

  task automatic load_w(input int n_words, input int last_idx);
    for (int i = 0; i < n_words; i++) push_w(wbuf[i], (i == last_idx));
  endtask

  task automatic send_x(input logic [31:0] x0, input logic [31:0] x1,
                        input logic [31:0] x2, input logic [31:0] x3);
    push_x(x0, 1'b0);
    push_x(x1, 1'b0);
    push_x(x2, 1'b0);
    push_x(x3, 1'b1);
  endtask

  // Waits for a result word, optionally stalls, checks it and accepts it.
  task automatic pop_out(input logic [31:0] exp_d, input logic exp_l,
                         input int stall, output int waited);
    int n = 0;
    while (OUTPUT_AXIS_TVALID !== 1'b1 && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    waited = n;
    check("out_tvalid_wait", 32'(OUTPUT_AXIS_TVALID), 32'd1);
    for (int k = 0; k < stall; k++) begin
      @(posedge aclk);
      #1;
      check("stall_tvalid", 32'(OUTPUT_AXIS_TVALID), 32'd1);
      check("stall_tdata", OUTPUT_AXIS_TDATA, exp_d);
    end
    check("out_tdata", OUTPUT_AXIS_TDATA, exp_d);
    check("out_tlast", 32'(OUTPUT_AXIS_TLAST), 32'(exp_l));
    OUTPUT_AXIS_TREADY = 1'b1;
    @(posedge aclk);
    #1;
    OUTPUT_AXIS_TREADY = 1'b0;
  endtask

  task automatic collect(input int stall, input logic timing);
    int w;
    for (int c = 0; c < 4; c++) begin
      pop_out(exp_out[c], (c == 3), stall, w);
      if (timing) check("latency_cycles", 32'(w), 32'd5);
    end
    repeat (8) @(posedge aclk);
    #1;
    check("no_extra_word", 32'(OUTPUT_AXIS_TVALID), 32'd0);
  endtask

  task automatic main_weights();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        wbuf[r*4 + c] = 32'(r + c + 1) << 16;
  endtask

  task automatic clear_weights();
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h0;
  endtask

  task automatic main_expect();
    exp_out[0] = 32'h001E0000;
    exp_out[1] = 32'h00280000;
    exp_out[2] = 32'h00320000;
    exp_out[3] = 32'h003C0000;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_w_tready"},  32'(WEIGHT_AXIS_TREADY), 32'd0);
    check({tag, "_in_tready"}, 32'(INPUT_AXIS_TREADY),  32'd0);
    check({tag, "_tvalid"},    32'(OUTPUT_AXIS_TVALID), 32'd0);
    check({tag, "_tlast"},     32'(OUTPUT_AXIS_TLAST),  32'd0);
    check({tag, "_tdata"},     OUTPUT_AXIS_TDATA,       32'd0);
    check({tag, "_wvalid"},    32'(weights_valid),      32'd0);
    check({tag, "_ferr"},      32'(frame_error),        32'd0);
  endtask

  initial begin
    int n;
    WEIGHT_AXIS_TDATA  = '0;
    WEIGHT_AXIS_TLAST  = 1'b0;
    WEIGHT_AXIS_TVALID = 1'b0;
    INPUT_AXIS_TDATA   = '0;
    INPUT_AXIS_TLAST   = 1'b0;
    INPUT_AXIS_TVALID  = 1'b0;
    OUTPUT_AXIS_TREADY = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    idle_outputs("reset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // No weights loaded: input must stay blocked
    INPUT_AXIS_TDATA  = 32'h00010000;
    INPUT_AXIS_TVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk);
      #1;
      check("noweights_in_tready", 32'(INPUT_AXIS_TREADY), 32'd0);
    end
    check("noweights_tvalid", 32'(OUTPUT_AXIS_TVALID), 32'd0);
    INPUT_AXIS_TVALID = 1'b0;

    // Main weight set
    main_weights();
    load_w(16, 15);
    check("load_wvalid", 32'(weights_valid), 32'd1);
    check("load_ferr", 32'(frame_error), 32'd0);

    // Weight beat wins over input beat in IDLE
    WEIGHT_AXIS_TVALID = 1'b1;
    INPUT_AXIS_TVALID  = 1'b1;
    #1;
    check("arb_in_tready_blocked", 32'(INPUT_AXIS_TREADY), 32'd0);
    WEIGHT_AXIS_TVALID = 1'b0;
    #1;
    check("arb_in_tready_open", 32'(INPUT_AXIS_TREADY), 32'd1);
    INPUT_AXIS_TVALID = 1'b0;

    // Basic vector, latency and gap
    main_expect();
    send_x(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
    collect(0, 1'b1);
    check("basic_ferr", 32'(frame_error), 32'd0);

    // Same vector under output back-pressure
    send_x(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
    collect(10, 1'b0);

    // Positive saturation
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h00020000;
    load_w(16, 15);
    for (int c = 0; c < 4; c++) exp_out[c] = 32'h7FFFFFFF;
    send_x(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
    collect(0, 1'b0);

    // Negative product: -0.5 * 1.5
    clear_weights();
    for (int c = 0; c < 4; c++) wbuf[c] = 32'h00018000;
    load_w(16, 15);
    for (int c = 0; c < 4; c++) exp_out[c] = 32'hFFFF4000;
    send_x(32'hFFFF8000, 32'h0, 32'h0, 32'h0);
    collect(0, 1'b0);

    // Rounding: +half LSB rounds up
    clear_weights();
    wbuf[0] = 32'h00008000;
    load_w(16, 15);
    exp_out[0] = 32'h00000001;
    for (int c = 1; c < 4; c++) exp_out[c] = 32'h0;
    send_x(32'h00000001, 32'h0, 32'h0, 32'h0);
    collect(0, 1'b0);

    // Rounding: -half LSB rounds toward +inf to zero
    wbuf[0] = 32'hFFFF8000;
    load_w(16, 15);
    for (int c = 0; c < 4; c++) exp_out[c] = 32'h0;
    send_x(32'h00000001, 32'h0, 32'h0, 32'h0);
    collect(0, 1'b0);
    check("round_ferr", 32'(frame_error), 32'd0);

    // Early weight TLAST on word 10
    main_weights();
    load_w(10, 9);
    check("early_ferr", 32'(frame_error), 32'd1);
    check("early_wvalid", 32'(weights_valid), 32'd0);
    INPUT_AXIS_TDATA  = 32'h00010000;
    INPUT_AXIS_TVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk);
      #1;
      check("early_in_tready", 32'(INPUT_AXIS_TREADY), 32'd0);
    end
    INPUT_AXIS_TVALID = 1'b0;

    // Reset while a result is pending in SEND
    load_w(16, 15);
    send_x(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
    n = 0;
    while (OUTPUT_AXIS_TVALID !== 1'b1 && n < 50) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("pre_reset_tvalid", 32'(OUTPUT_AXIS_TVALID), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    idle_outputs("midsend_reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // Reload and rerun the basic case
    main_weights();
    load_w(16, 15);
    check("reload_wvalid", 32'(weights_valid), 32'd1);
    main_expect();
    send_x(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000);
    collect(0, 1'b1);
    check("rerun_ferr", 32'(frame_error), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
